core_scheduler: RTL and testbench
=================================

# core_scheduler

Sequencing controller for `computing_core`. For each tile it walks output rows × input-channel groups (8 channels per group) and issues weight/activation buffer reads. It tracks the fixed pipeline latency of buffer + core, and tags each result leaving the core with valid/first/last strobes so the downstream accumulator can clear, accumulate and retire partial sums. One tile runs per start pulse.

## Interface
- `CIN_GRP_W`, 6: width of the channel-group count.
- `ROW_W`, 8: width of the row count.
- `ADDR_W`, 12: buffer read-address width.
- `CORE_LAT`, 4: cycles from a read issue (`o_rd_en` high) to the matching `computing_core.o_result` being valid; ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: start pulse; honoured only in IDLE.
- `i_cin_groups` in CIN_GRP_W: channel groups per row; latched at start.
- `i_rows` in ROW_W: rows per tile; latched at start.
- `i_act_ready` in 1: activation buffer holds data for the next read; low inserts a bubble.
- `o_busy` out 1: tile in progress.
- `o_done` out 1: one-cycle tile-complete pulse.
- `o_err` out 1: one-cycle pulse when a start is rejected.
- `o_rd_en` out 1: weight and activation read strobe (shared).
- `o_w_rd_addr` out ADDR_W: weight address = current group index.
- `o_a_rd_addr` out ADDR_W: activation address = row × groups + group, generated as a linear counter.
- `o_acc_valid` out 1: core result valid this cycle.
- `o_acc_first` out 1: result is group 0 of its row; accumulator clears.
- `o_acc_last` out 1: result is the last group of its row; accumulator retires.
- `o_bubble_cnt` out 16: count of bubble cycles (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `i_start` with a nonzero group count and a nonzero row count: latch the config, clear the counters, go to RUN.
  - `i_start` with either count zero: stay in IDLE and pulse `o_err` the next cycle.
- **RUN**
  - Each cycle with `i_act_ready`=1: assert `o_rd_en` with the current addresses, then advance.
    - The group counter increments.
    - On wrap (group = groups−1) the group counter resets to 0 and the row counter increments.
    - The activation address increments every issue and wraps mod 2^ADDR_W.
  - Cycle with `i_act_ready`=0: `o_rd_en`=0, the counters hold, and a bubble enters the delay line.
  - Issuing the last (row, group) pair moves the state to DRAIN.
- **Delay line**
  - CORE_LAT-deep shift register of {valid, first, last}; shifts every cycle with no stall.
  - The output stage drives the `o_acc_*` strobes.
- **DRAIN**
  - Down-counter loaded with CORE_LAT−1 on entry.
  - At zero the last result has been presented; go to DONE.
- **DONE**
  - `o_done`=1 for one cycle, then IDLE.
- `i_start` outside IDLE is ignored: no `o_err` and no effect on the config.
- Address arithmetic is unsigned and truncated to ADDR_W.
- The config registers are not sampled outside the start cycle.

## Timing
- Reset values:
  - State IDLE; all counters 0; delay line empty.
  - All outputs 0, including `o_bubble_cnt`.
- Start sampled at edge T0 → `o_busy`=1 from T1 through the `o_done` cycle inclusive, 0 afterwards.
- The first possible `o_rd_en` is at T1.
- An issue at cycle t produces `o_acc_valid` at t+CORE_LAT, with first/last aligned to it.
- `o_done` rises exactly one cycle after the final `o_acc_valid`&`o_acc_last`.
- `o_err` rises at T1 for a rejected start.
- The earliest re-start is accepted in the cycle after `o_done`.
- Reset asserted mid-tile:
  - Immediate return to IDLE; the delay line is flushed.
  - No `o_done` and no further `o_acc_valid`.

## Configuration
- `CORE_SCHED_PERF_CNT_EN` defined:
  - `o_bubble_cnt` counts RUN cycles with `i_act_ready`=0, saturating at 16'hFFFF.
  - Cleared on an accepted start; holds its value after `o_done`.
- Not defined: `o_bubble_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Basic tile** (groups=2, rows=3, `i_act_ready`=1, CORE_LAT=4), start at T0:
  - `o_rd_en` T1–T6; w addr 0,1,0,1,0,1; a addr 0–5.
  - `o_acc_valid` T5–T10; first at T5/T7/T9, last at T6/T8/T10.
  - `o_done` T11; `o_busy` T1–T11.
- **Bubbles**: same tile with `i_act_ready`=0 at T2 and T3:
  - Issues at T1 and T4–T8.
  - `o_acc_valid` gap at T6–T7; `o_done` T13.
  - With the macro defined, `o_bubble_cnt`=2.
- **Zero config**: start with groups=0 → `o_err` at T1, `o_busy` stays 0, no reads; the same result for rows=0.
- **Start while busy**: a second `i_start` with different counts during RUN → ignored; the original tile completes with the original addresses.
- **Reset mid-tile**: assert `rst` at T3 of the basic tile → all outputs 0 at once; no `o_done`; a new start after release runs cleanly from address 0.
- **Address wrap**: ADDR_W=4, groups=5, rows=4 (20 issues) → `o_a_rd_addr` runs 0–15 then 0–3; single-group case (groups=1) sets first and last together on every result.

Source files
------------

// File: rtl/core_scheduler.sv
// Tile sequencer for computing_core: walks rows x channel groups, issues buffer reads and
// tags core results with valid/first/last. Optional bubble counter: CORE_SCHED_PERF_CNT_EN.
module core_scheduler #(
  parameter int CIN_GRP_W = 6,
  parameter int ROW_W     = 8,
  parameter int ADDR_W    = 12,
  parameter int CORE_LAT  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [CIN_GRP_W-1:0] i_cin_groups,
  input  logic [ROW_W-1:0]     i_rows,
  input  logic                 i_act_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_rd_en,
  output logic [ADDR_W-1:0]    o_w_rd_addr,
  output logic [ADDR_W-1:0]    o_a_rd_addr,
  output logic                 o_acc_valid,
  output logic                 o_acc_first,
  output logic                 o_acc_last,
  output logic [15:0]          o_bubble_cnt
);

  localparam int                   DRAIN_W    = $clog2(CORE_LAT) + 1;
  localparam logic [DRAIN_W-1:0]   DRAIN_LOAD = DRAIN_W'(CORE_LAT - 1);
  localparam logic [CIN_GRP_W-1:0] GRP_ONE    = CIN_GRP_W'(1);
  localparam logic [ROW_W-1:0]     ROW_ONE    = ROW_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [CIN_GRP_W-1:0] groups_reg;
  logic [ROW_W-1:0]     rows_reg;
  logic [CIN_GRP_W-1:0] grp_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [ADDR_W-1:0]    a_addr_reg;
  logic [DRAIN_W-1:0]   drain_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic issue;
  logic start_ok;
  logic grp_last;
  logic row_last;

  assign issue    = (state_reg == RUN) && i_act_ready;
  assign start_ok = i_start && (i_cin_groups != '0) && (i_rows != '0);
  assign grp_last = (grp_reg == groups_reg - GRP_ONE);
  assign row_last = (row_reg == rows_reg - ROW_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      groups_reg <= '0;
      rows_reg   <= '0;
      grp_reg    <= '0;
      row_reg    <= '0;
      a_addr_reg <= '0;
      drain_reg  <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            groups_reg <= i_cin_groups;
            rows_reg   <= i_rows;
            grp_reg    <= '0;
            row_reg    <= '0;
            a_addr_reg <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= RUN;
          end else if (i_start) begin
            err_reg <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            a_addr_reg <= a_addr_reg + ADDR_W'(1);
            if (grp_last) begin
              grp_reg <= '0;
              row_reg <= row_reg + ROW_ONE;
              if (row_last) begin
                drain_reg <= DRAIN_LOAD;
                state_reg <= DRAIN;
              end
            end else begin
              grp_reg <= grp_reg + GRP_ONE;
            end
          end
        end
        DRAIN: begin
          // Count hits zero in the cycle the last result sits on the acc strobes.
          if (drain_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            drain_reg <= drain_reg - DRAIN_W'(1);
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Fixed-latency tag pipe {valid, first, last}; bubbles travel as all-zero entries.
  logic [2:0] dly_reg [CORE_LAT];

  generate
    for (genvar gi = 0; gi < CORE_LAT; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge clk or posedge rst) begin
          if (rst) dly_reg[gi] <= '0;
          else     dly_reg[gi] <= {issue, issue && (grp_reg == '0), issue && grp_last};
        end
      end else begin : g_tail
        always_ff @(posedge clk or posedge rst) begin
          if (rst) dly_reg[gi] <= '0;
          else     dly_reg[gi] <= dly_reg[gi-1];
        end
      end
    end
  endgenerate

  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_err       = err_reg;
  assign o_rd_en     = issue;
  assign o_w_rd_addr = ADDR_W'(grp_reg);
  assign o_a_rd_addr = a_addr_reg;
  assign o_acc_valid = dly_reg[CORE_LAT-1][2];
  assign o_acc_first = dly_reg[CORE_LAT-1][1];
  assign o_acc_last  = dly_reg[CORE_LAT-1][0];

`ifdef CORE_SCHED_PERF_CNT_EN
  logic [15:0] bubble_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_reg <= '0;
    end else if ((state_reg == IDLE) && start_ok) begin
      bubble_cnt_reg <= '0;
    end else if ((state_reg == RUN) && !i_act_ready && (bubble_cnt_reg != 16'hFFFF)) begin
      bubble_cnt_reg <= bubble_cnt_reg + 16'd1;
    end
  end

  assign o_bubble_cnt = bubble_cnt_reg;
`else
  assign o_bubble_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: two instances (ADDR_W=12 and ADDR_W=4) share stimulus,
// every output is compared cycle by cycle against hand-derived schedules.
module tb_core_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [5:0]  cfg_groups;
  logic [7:0]  cfg_rows;
  logic        act_ready;

  logic        busy_a, done_a, err_a, rd_a, v_a, f_a, l_a;
  logic [11:0] w_a, aa_a;
  logic [15:0] bc_a;
  logic        busy_b, done_b, err_b, rd_b, v_b, f_b, l_b;
  logic [3:0]  w_b, aa_b;
  logic [15:0] bc_b;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  core_scheduler #(.CIN_GRP_W(6), .ROW_W(8), .ADDR_W(12), .CORE_LAT(4)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cin_groups(cfg_groups), .i_rows(cfg_rows),
    .i_act_ready(act_ready), .o_busy(busy_a), .o_done(done_a), .o_err(err_a),
    .o_rd_en(rd_a), .o_w_rd_addr(w_a), .o_a_rd_addr(aa_a), .o_acc_valid(v_a),
    .o_acc_first(f_a), .o_acc_last(l_a), .o_bubble_cnt(bc_a)
  );

  core_scheduler #(.CIN_GRP_W(6), .ROW_W(8), .ADDR_W(4), .CORE_LAT(4)) dut_w (
    .clk(clk), .rst(rst), .i_start(i_start), .i_cin_groups(cfg_groups), .i_rows(cfg_rows),
    .i_act_ready(act_ready), .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
    .o_rd_en(rd_b), .o_w_rd_addr(w_b), .o_a_rd_addr(aa_b), .o_acc_valid(v_b),
    .o_acc_first(f_b), .o_acc_last(l_b), .o_bubble_cnt(bc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Both instances must sit quiet: no reads, no strobes, not busy.
  task automatic check_quiet(input string tag);
    check({tag, " busy_a"}, 32'(busy_a), 32'd0);
    check({tag, " busy_b"}, 32'(busy_b), 32'd0);
    check({tag, " rd_a"},   32'(rd_a),   32'd0);
    check({tag, " rd_b"},   32'(rd_b),   32'd0);
    check({tag, " vld_a"},  32'(v_a),    32'd0);
    check({tag, " vld_b"},  32'(v_b),    32'd0);
    check({tag, " done_a"}, 32'(done_a), 32'd0);
    check({tag, " done_b"}, 32'(done_b), 32'd0);
  endtask

  // Cycle k is the period ending at edge Tk; start is high in cycle 0, sampled at edge T0.
  // stall bit k drops act_ready in cycle k; xs>0 fires a rogue start (3 groups x 1 row) then.
  task automatic run_tile(input string name, input int g, input int r, input logic [63:0] stall,
                          input int exp_done, input int xs, input int exp_bub);
    logic [63:0] ev, ef, el;
    logic        exp_rd;
    int          n;
    string       t;
    ev = '0; ef = '0; el = '0; n = 0;
    for (int k = 0; k <= exp_done; k++) begin
      @(posedge clk); #1;
      i_start    = (k == 0) || (k == xs);
      cfg_groups = (k == xs) ? 6'd3 : 6'(g);
      cfg_rows   = (k == xs) ? 8'd1 : 8'(r);
      act_ready  = !stall[k];
      #4;
      t = $sformatf("%s T%0d", name, k);
      exp_rd = (k >= 1) && (n < g * r) && !stall[k];
      check({t, " rd_a"}, 32'(rd_a), 32'(exp_rd));
      check({t, " rd_b"}, 32'(rd_b), 32'(exp_rd));
      check({t, " vld_a"}, 32'(v_a), 32'(ev[k]));
      check({t, " vld_b"}, 32'(v_b), 32'(ev[k]));
      check({t, " first_a"}, 32'(f_a), 32'(ef[k]));
      check({t, " first_b"}, 32'(f_b), 32'(ef[k]));
      check({t, " last_a"}, 32'(l_a), 32'(el[k]));
      check({t, " last_b"}, 32'(l_b), 32'(el[k]));
      check({t, " busy_a"}, 32'(busy_a), 32'((k >= 1) && (k <= exp_done)));
      check({t, " busy_b"}, 32'(busy_b), 32'((k >= 1) && (k <= exp_done)));
      check({t, " done_a"}, 32'(done_a), 32'(k == exp_done));
      check({t, " done_b"}, 32'(done_b), 32'(k == exp_done));
      check({t, " err_a"}, 32'(err_a), 32'd0);
      if (exp_rd) begin
        check({t, " waddr_a"}, 32'(w_a), 32'(n % g));
        check({t, " waddr_b"}, 32'(w_b), 32'(n % g));
        check({t, " aaddr_a"}, 32'(aa_a), 32'(n % 4096));
        check({t, " aaddr_b"}, 32'(aa_b), 32'(n % 16));
        ev[k+4] = 1'b1;
        ef[k+4] = (n % g) == 0;
        el[k+4] = (n % g) == (g - 1);
        n++;
      end
    end
    check({name, " issues"}, 32'(n), 32'(g * r));
`ifdef CORE_SCHED_PERF_CNT_EN
    check({name, " bubbles_a"}, 32'(bc_a), 32'(exp_bub));
    check({name, " bubbles_b"}, 32'(bc_b), 32'(exp_bub));
`else
    check({name, " bubbles_a"}, 32'(bc_a), 32'd0);
    check({name, " bubbles_b"}, 32'(bc_b), 32'd0);
    if (exp_bub < 0) $display("unexpected bubble argument");
`endif
    act_ready = 1'b1;
  endtask

  task automatic zero_cfg(input string name, input int g, input int r);
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); #1;
      i_start    = (k == 0);
      cfg_groups = 6'(g);
      cfg_rows   = 8'(r);
      #4;
      check($sformatf("%s T%0d err_a", name, k), 32'(err_a), 32'(k == 1));
      check($sformatf("%s T%0d err_b", name, k), 32'(err_b), 32'(k == 1));
      check_quiet($sformatf("%s T%0d", name, k));
    end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; cfg_groups = '0; cfg_rows = '0; act_ready = 1'b1;
    repeat (2) @(posedge clk);
    #5;
    check_quiet("reset");
    check("reset err_a", 32'(err_a), 32'd0);
    check("reset aaddr_a", 32'(aa_a), 32'd0);
    check("reset waddr_a", 32'(w_a), 32'd0);
    check("reset first_a", 32'(f_a), 32'd0);
    check("reset last_a", 32'(l_a), 32'd0);
    check("reset bubbles_a", 32'(bc_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back runs also exercise the earliest legal restart.
    run_tile("basic",  2, 3, 64'h0,  11, -1, 0);
    run_tile("bubble", 2, 3, 64'hC,  13, -1, 2);
    run_tile("busy_start", 2, 3, 64'h0, 11, 3, 0);
    run_tile("wrap",   5, 4, 64'h0,  25, -1, 0);
    run_tile("single", 1, 3, 64'h0,  8,  -1, 0);
    zero_cfg("zero_grp", 0, 3);
    zero_cfg("zero_row", 2, 0);

    // Reset asserted in cycle T3 of a basic tile.
    for (int k = 0; k <= 14; k++) begin
      @(posedge clk); #1;
      i_start    = (k == 0);
      cfg_groups = 6'd2;
      cfg_rows   = 8'd3;
      rst        = (k == 3) || (k == 4);
      #4;
      if (k >= 3) check_quiet($sformatf("midrst T%0d", k));
    end
    run_tile("post_rst", 2, 3, 64'h0, 11, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
